// File: rtl/data_memory_ws_if.sv
// Bus between the CPU MEM stage and the wait-stated data memory.
// The CPU drives the request side (master); the memory answers with
// ReadData and the Busy/Ready/MemError handshake (slave).
interface data_memory_ws_if #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 24
);
    logic                  MemRead;
    logic                  MemWrite;
    logic [ADDR_W-1:0]     Adresa;
    logic [DATA_W-1:0]     WriteData;
    logic [DATA_W/8-1:0]   ByteEn;
    logic [DATA_W-1:0]     ReadData;
    logic                  Busy;
    logic                  Ready;
    logic                  MemError;

    modport master (
        output MemRead, MemWrite, Adresa, WriteData, ByteEn,
        input  ReadData, Busy, Ready, MemError
    );

    modport slave (
        input  MemRead, MemWrite, Adresa, WriteData, ByteEn,
        output ReadData, Busy, Ready, MemError
    );
endinterface

// File: rtl/data_memory_ws.sv
// Word-addressed data memory with byte-lane writes, a configurable number
// of wait states and a Busy/Ready handshake. A request is latched in IDLE,
// waits WAIT_STATES cycles, then commits in DONE; Ready pulses for the one
// cycle after the commit, qualified by MemError for out-of-range addresses
// or simultaneous read+write requests.
module data_memory_ws #(
    parameter int DATA_W      = 24,
    parameter int ADDR_W      = 24,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic              clock,
    input  logic              reset,
    data_memory_ws_if.slave   bus
);
    localparam int LANES = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_rd;
    logic                r_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [LANES-1:0]    r_be;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_busy;
    logic                r_ready;
    logic                r_err;

    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_req;
    logic                w_in_range;
    logic [IDX_W-1:0]    w_idx;
    logic                w_conflict;
    logic                w_do_write;

    assign w_req      = bus.MemRead | bus.MemWrite;
    // Full-width compare so aliased high addresses are still rejected.
    assign w_in_range = (r_addr < ADDR_W'(DEPTH));
    assign w_idx      = r_addr[IDX_W-1:0];
    assign w_conflict = r_rd & r_wr;
    // Reset at the commit edge suppresses the write as well.
    assign w_do_write = (r_state == S_DONE) && r_wr && !r_rd && w_in_range && !reset;

    assign bus.ReadData = r_rdata;
    assign bus.Busy     = r_busy;
    assign bus.Ready    = r_ready;
    assign bus.MemError = r_err;

    // Request FSM: latch in IDLE, count wait states, commit and pulse Ready.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= '0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_rd    <= bus.MemRead;
                        r_wr    <= bus.MemWrite;
                        r_addr  <= bus.Adresa;
                        r_wdata <= bus.WriteData;
                        r_be    <= bus.ByteEn;
                        r_busy  <= 1'b1;
                        r_cnt   <= 4'(WAIT_STATES);
                        r_state <= (WAIT_STATES == 0) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_err   <= w_conflict | !w_in_range;
                    if (r_rd && !r_wr) begin
                        r_rdata <= w_in_range ? r_mem[w_idx] : '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: byte-lane write at the commit edge; contents survive reset.
    always_ff @(posedge clock) begin
        if (w_do_write) begin
            for (int i = 0; i < LANES; i++) begin
                if (r_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_data_memory_ws.sv
// Bench for data_memory_ws: one instance with one wait state, one with none.
// A word-array reference model tracks memory contents and expected ReadData.
module tb_data_memory_ws;
    localparam int DW    = 24;
    localparam int AW    = 24;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1;
    logic rst0;

    data_memory_ws_if #(.DATA_W(DW), .ADDR_W(AW)) b1 ();
    data_memory_ws_if #(.DATA_W(DW), .ADDR_W(AW)) b0 ();

    data_memory_ws #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_STATES(1)) dut1 (
        .clock(clk), .reset(rst1), .bus(b1));
    data_memory_ws #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .clock(clk), .reset(rst0), .bus(b0));

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] mdl  [2][DEPTH];
    logic [DW-1:0] rexp [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int w, input bit rd, input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [2:0] be);
        if (w == 1) begin
            b1.MemRead = rd; b1.MemWrite = wr; b1.Adresa = a; b1.WriteData = d; b1.ByteEn = be;
        end else begin
            b0.MemRead = rd; b0.MemWrite = wr; b0.Adresa = a; b0.WriteData = d; b0.ByteEn = be;
        end
    endtask

    function automatic logic f_busy(input int w);
        return (w == 1) ? b1.Busy : b0.Busy;
    endfunction
    function automatic logic f_ready(input int w);
        return (w == 1) ? b1.Ready : b0.Ready;
    endfunction
    function automatic logic f_err(input int w);
        return (w == 1) ? b1.MemError : b0.MemError;
    endfunction
    function automatic logic [DW-1:0] f_rdata(input int w);
        return (w == 1) ? b1.ReadData : b0.ReadData;
    endfunction

    // Reference behaviour of one accepted request.
    task automatic model(input int w, input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [2:0] be, output bit err);
        err = 1'b0;
        if (rd && wr) begin
            err = 1'b1;
        end else if (a >= AW'(DEPTH)) begin
            err = 1'b1;
            if (rd) rexp[w] = '0;
        end else if (rd) begin
            rexp[w] = mdl[w][a[7:0]];
        end else begin
            for (int i = 0; i < 3; i++)
                if (be[i]) mdl[w][a[7:0]][8*i +: 8] = d[8*i +: 8];
        end
    endtask

    // One request; junk: 0 idle while busy, 1 random inputs, 2 write of addr 3.
    task automatic txn(input int w, input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [2:0] be, input int junk);
        int lat;
        int n;
        bit got;
        bit err;
        lat = (w == 1) ? 2 : 1;
        n = 0;
        got = 1'b0;
        @(negedge clk);
        set_in(w, rd, wr, a, d, be);
        @(posedge clk); #1;
        chk("busy_accept", 32'(f_busy(w)), 32'd1);
        if (junk == 1)
            set_in(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom),
                   DW'($urandom), 3'($urandom));
        else if (junk == 2)
            set_in(w, 1'b0, 1'b1, 24'd3, 24'hFFFFFF, 3'b111);
        else
            set_in(w, 1'b0, 1'b0, a, d, be);
        model(w, rd, wr, a, d, be, err);
        while (n < 20 && !got) begin
            @(posedge clk); #1;
            n++;
            if (f_ready(w)) begin
                got = 1'b1;
                set_in(w, 1'b0, 1'b0, '0, '0, '0);
            end
        end
        chk("latency", 32'(n), 32'(lat));
        chk("memerror", 32'(f_err(w)), 32'(err));
        chk("readdata", 32'(f_rdata(w)), 32'(rexp[w]));
        chk("busy_done", 32'(f_busy(w)), 32'd0);
        @(posedge clk); #1;
        chk("ready_pulse", 32'(f_ready(w)), 32'd0);
    endtask

    initial begin
        bit seen;
        logic [DW-1:0] old9;
        int kind;
        int ar;
        logic [AW-1:0] a;

        set_in(1, 1'b0, 1'b0, '0, '0, '0);
        set_in(0, 1'b0, 1'b0, '0, '0, '0);
        rst1 = 1'b1;
        rst0 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            chk("rst_busy", 32'(f_busy(w)), 32'd0);
            chk("rst_ready", 32'(f_ready(w)), 32'd0);
            chk("rst_err", 32'(f_err(w)), 32'd0);
            chk("rst_rdata", 32'(f_rdata(w)), 32'd0);
            rexp[w] = '0;
        end
        rst1 = 1'b0;
        rst0 = 1'b0;

        // Give every word a known value.
        for (int ad = 0; ad < DEPTH; ad++) begin
            txn(1, 1'b0, 1'b1, AW'(ad), DW'($urandom), 3'b111, 0);
            txn(0, 1'b0, 1'b1, AW'(ad), DW'($urandom), 3'b111, 0);
        end

        // Write then read back with one wait state.
        txn(1, 1'b0, 1'b1, 24'd2, 24'd7, 3'b111, 0);
        txn(1, 1'b1, 1'b0, 24'd2, 24'd0, 3'b000, 0);
        chk("t1_value", 32'(f_rdata(1)), 32'd7);

        // Byte-lane merge.
        txn(1, 1'b0, 1'b1, 24'd5, 24'hABCDEF, 3'b111, 0);
        txn(1, 1'b0, 1'b1, 24'd5, 24'h123456, 3'b010, 0);
        txn(1, 1'b1, 1'b0, 24'd5, 24'd0, 3'b000, 0);
        chk("t2_value", 32'(f_rdata(1)), 32'hAB34EF);
        txn(1, 1'b0, 1'b1, 24'd5, 24'h999999, 3'b000, 0);
        txn(1, 1'b1, 1'b0, 24'd5, 24'd0, 3'b000, 0);

        // Out of range: no aliasing write, read returns zero.
        txn(1, 1'b0, 1'b1, 24'd300, 24'h55, 3'b111, 0);
        txn(1, 1'b1, 1'b0, 24'd44, 24'd0, 3'b000, 0);
        txn(1, 1'b1, 1'b0, 24'd300, 24'd0, 3'b000, 0);
        chk("t3_zero", 32'(f_rdata(1)), 32'd0);
        txn(1, 1'b1, 1'b0, 24'h800002, 24'd0, 3'b000, 0);

        // Inputs changed while busy are ignored.
        txn(1, 1'b1, 1'b0, 24'd2, 24'd0, 3'b000, 2);
        chk("t4_value", 32'(f_rdata(1)), 32'd7);
        txn(1, 1'b1, 1'b0, 24'd3, 24'd0, 3'b000, 0);

        // Reset during WAIT aborts the write.
        old9 = mdl[1][9];
        @(negedge clk);
        set_in(1, 1'b0, 1'b1, 24'd9, 24'h00FF00, 3'b111);
        @(posedge clk); #1;
        chk("t5_busy", 32'(f_busy(1)), 32'd1);
        set_in(1, 1'b0, 1'b0, '0, '0, '0);
        rst1 = 1'b1;
        @(posedge clk); #1;
        rst1 = 1'b0;
        rexp[1] = '0;
        chk("t5_busy_rst", 32'(f_busy(1)), 32'd0);
        chk("t5_rdata_rst", 32'(f_rdata(1)), 32'd0);
        seen = (f_ready(1) === 1'b1);
        repeat (4) begin
            @(posedge clk); #1;
            if (f_ready(1) === 1'b1) seen = 1'b1;
        end
        chk("t5_no_ready", 32'(seen), 32'd0);
        txn(1, 1'b1, 1'b0, 24'd9, 24'd0, 3'b000, 0);
        chk("t5_kept", 32'(f_rdata(1)), 32'(old9));

        // Zero wait states, back-to-back reads with MemRead held.
        @(negedge clk);
        set_in(0, 1'b1, 1'b0, 24'd0, '0, '0);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            chk("t6_busy", 32'(f_busy(0)), 32'd1);
            chk("t6_ready_lo", 32'(f_ready(0)), 32'd0);
            @(posedge clk); #1;
            chk("t6_ready_hi", 32'(f_ready(0)), 32'd1);
            chk("t6_rdata", 32'(f_rdata(0)), 32'(mdl[0][k]));
            chk("t6_err", 32'(f_err(0)), 32'd0);
            rexp[0] = mdl[0][k];
            if (k < 2) begin
                set_in(0, 1'b1, 1'b0, AW'(k + 1), '0, '0);
                @(posedge clk); #1;
            end else begin
                set_in(0, 1'b0, 1'b0, '0, '0, '0);
            end
        end
        @(posedge clk); #1;
        chk("t6_idle", 32'(f_ready(0)), 32'd0);
        txn(0, 1'b1, 1'b1, 24'd7, 24'h0BAD00, 3'b111, 0);
        txn(0, 1'b1, 1'b0, 24'd7, 24'd0, 3'b000, 0);

        // Randomized traffic on both instances.
        for (int it = 0; it < 160; it++) begin
            kind = $urandom_range(0, 5);
            ar = $urandom_range(0, 9);
            if (ar < 8) a = AW'($urandom_range(0, DEPTH - 1));
            else if (ar == 8) a = AW'($urandom_range(DEPTH, 400));
            else a = AW'($urandom) | 24'h010000;
            txn(it % 2, (kind < 3) || (kind == 5), kind >= 3, a, DW'($urandom),
                3'($urandom), $urandom_range(0, 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
